// File: rtl/rv32i_core_top.sv
// Single-cycle RV32I core with private instruction/data memories and an mscratch CSR.
// Optional 64-bit mcycle/minstret counters are enabled with the CSR_COUNTER_EN macro.
module rv32i_core_top #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] boot_addr
);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
`ifdef CSR_COUNTER_EN
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
`endif

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] mscratch_q, mscratch_d;
`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`endif

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;
  logic [31:0] mem_addr, ld_word;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic        rd_we;
  logic [31:0] rd_val;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        csr_we;
  logic [31:0] csr_old, csr_src, csr_wdata;
  logic        br_taken;
  logic        unused_bits;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0:    r = alt ? (a - b) : (a + b);
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'd0, $signed(a) < $signed(b)};
      3'd3:    r = {31'd0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Field decode and immediates
  always_comb begin
    instr    = imem[pc_q[11:2]];
    opcode   = instr[6:0];
    rd       = instr[11:7];
    funct3   = instr[14:12];
    rs1      = instr[19:15];
    rs2      = instr[24:20];
    csr_addr = instr[31:20];
    imm_i    = {{20{instr[31]}}, instr[31:20]};
    imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u    = {instr[31:12], 12'd0};
    imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    rs1_val  = rf_q[rs1];
    rs2_val  = rf_q[rs2];
    pc_plus4 = pc_q + 32'd4;
  end

  // Memory address and load lane extraction
  always_comb begin
    mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    ld_word  = dmem[mem_addr[10:2]];
    ld_byte  = ld_word[{mem_addr[1:0], 3'b000} +: 8];
    ld_half  = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];
    unused_bits = &{1'b0, mem_addr[31:11]};
  end

  // CSR read mux; unimplemented addresses read zero
  always_comb begin
    csr_old = 32'd0;
    case (csr_addr)
      CSR_MSCRATCH:  csr_old = mscratch_q;
`ifdef CSR_COUNTER_EN
      CSR_MCYCLE:    csr_old = mcycle_q[31:0];
      CSR_MCYCLEH:   csr_old = mcycle_q[63:32];
      CSR_MINSTRET:  csr_old = minstret_q[31:0];
      CSR_MINSTRETH: csr_old = minstret_q[63:32];
`endif
      default:       csr_old = 32'd0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'd0:    br_taken = (rs1_val == rs2_val);
      3'd1:    br_taken = (rs1_val != rs2_val);
      3'd4:    br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'd5:    br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6:    br_taken = (rs1_val < rs2_val);
      3'd7:    br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Execute: next pc, rd write, store lanes, CSR write
  always_comb begin
    pc_d      = pc_plus4;
    rd_we     = 1'b0;
    rd_val    = 32'd0;
    st_be     = 4'd0;
    st_data   = 32'd0;
    csr_we    = 1'b0;
    csr_wdata = 32'd0;
    csr_src   = funct3[2] ? {27'd0, rs1} : rs1_val;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = pc_q + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; rd_val = pc_plus4; pc_d = pc_q + imm_j; end
      OP_JALR:  begin rd_we = 1'b1; rd_val = pc_plus4; pc_d = (rs1_val + imm_i) & ~32'd1; end
      OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
      OP_LOAD: begin
        rd_we = 1'b1;
        case (funct3)
          3'd0:    rd_val = {{24{ld_byte[7]}}, ld_byte};
          3'd1:    rd_val = {{16{ld_half[15]}}, ld_half};
          3'd2:    rd_val = ld_word;
          3'd4:    rd_val = {24'd0, ld_byte};
          3'd5:    rd_val = {16'd0, ld_half};
          default: rd_we  = 1'b0;
        endcase
      end
      OP_STORE: begin
        case (funct3)
          3'd0:    begin st_be = 4'b0001 << mem_addr[1:0]; st_data = {4{rs2_val[7:0]}}; end
          3'd1:    begin st_be = mem_addr[1] ? 4'b1100 : 4'b0011; st_data = {2{rs2_val[15:0]}}; end
          3'd2:    begin st_be = 4'b1111; st_data = rs2_val; end
          default: st_be = 4'd0;
        endcase
      end
      OP_IMM: begin
        rd_we  = 1'b1;
        rd_val = alu(funct3, (funct3 == 3'd5) && instr[30], rs1_val, imm_i);
      end
      OP_REG: begin rd_we = 1'b1; rd_val = alu(funct3, instr[30], rs1_val, rs2_val); end
      OP_SYSTEM: begin
        if (funct3[1:0] != 2'd0) begin
          rd_we  = 1'b1;
          rd_val = csr_old;
          case (funct3[1:0])
            2'd1:    begin csr_we = 1'b1; csr_wdata = csr_src; end
            2'd2:    begin csr_we = (rs1 != 5'd0); csr_wdata = csr_old | csr_src; end
            default: begin csr_we = (rs1 != 5'd0); csr_wdata = csr_old & ~csr_src; end
          endcase
        end
      end
      default: pc_d = pc_plus4;
    endcase
    if (rst) st_be = 4'd0;
  end

  // CSR next state; an explicit write overrides the counter increment
  always_comb begin
    mscratch_d = (csr_we && csr_addr == CSR_MSCRATCH) ? csr_wdata : mscratch_q;
`ifdef CSR_COUNTER_EN
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + 64'd1;
    if (csr_we) begin
      case (csr_addr)
        CSR_MCYCLE:    mcycle_d[31:0]    = csr_wdata;
        CSR_MCYCLEH:   mcycle_d[63:32]   = csr_wdata;
        CSR_MINSTRET:  minstret_d[31:0]  = csr_wdata;
        CSR_MINSTRETH: minstret_d[63:32] = csr_wdata;
        default:       mcycle_d = mcycle_q + 64'd1;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= boot_addr;
      mscratch_q <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
`ifdef CSR_COUNTER_EN
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
`endif
    end else begin
      pc_q       <= pc_d;
      mscratch_q <= mscratch_d;
      if (rd_we && rd != 5'd0) rf_q[rd] <= rd_val;
`ifdef CSR_COUNTER_EN
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`endif
    end
  end

  // Data memory: byte-enable write, never reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (st_be[b]) dmem[mem_addr[10:2]][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_rv32i_core_top.sv
// Directed-program bench for rv32i_core_top: programs are preloaded into imem while
// reset is held, then architectural state is compared against hand-computed values.
module tb_rv32i_core_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] boot_addr = 32'd0;
  int          checks = 0;
  int          failures = 0;

  rv32i_core_top dut (.clk(clk), .rst(rst), .boot_addr(boot_addr));

  always #5 clk = ~clk;

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // Hold reset, set boot address and wipe both memories to NOP / zero
  task automatic begin_prog(input logic [31:0] boot);
    rst = 1'b1;
    boot_addr = boot;
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0000_0013;
    for (int i = 0; i < 512; i++) dut.dmem[i] = 32'd0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    begin_prog(32'hFFFF_0000);
    dut.imem[0] = i_t(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    dut.imem[1] = i_t(12'h340, 5'd1, 3'd1, 5'd0, 7'h73);
    release_rst();
    #1;
    checks++; if (dut.pc_q !== 32'hFFFF_0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", dut.pc_q, 32'hFFFF_0000); end
    checks++; if (dut.rf_q[1] !== 32'd0) begin failures++; $display("FAIL reset_x1 got=%h exp=0", dut.rf_q[1]); end
    checks++; if (dut.mscratch_q !== 32'd0) begin failures++; $display("FAIL reset_mscratch got=%h exp=0", dut.mscratch_q); end
    run(2);
    checks++; if (dut.mscratch_q !== 32'd5) begin failures++; $display("FAIL boot_mscratch got=%h exp=5", dut.mscratch_q); end
    checks++; if (dut.pc_q !== 32'hFFFF_0008) begin failures++; $display("FAIL boot_pc got=%h exp=%h", dut.pc_q, 32'hFFFF_0008); end
  endtask

  task automatic test_alu();
    begin_prog(32'd0);
    dut.imem[0] = u_t(20'h80000, 5'd1, 7'h37);
    dut.imem[1] = i_t(12'h404, 5'd1, 3'd5, 5'd2, 7'h13);
    dut.imem[2] = i_t(12'h004, 5'd1, 3'd5, 5'd6, 7'h13);
    dut.imem[3] = r_t(7'h00, 5'd1, 5'd0, 3'd3, 5'd3);
    dut.imem[4] = r_t(7'h00, 5'd0, 5'd1, 3'd2, 5'd4);
    dut.imem[5] = r_t(7'h20, 5'd6, 5'd2, 3'd0, 5'd7);
    dut.imem[6] = i_t(12'hFFF, 5'd0, 3'd0, 5'd8, 7'h13);
    dut.imem[7] = i_t(12'h0F0, 5'd8, 3'd4, 5'd9, 7'h13);
    release_rst();
    run(8);
    checks++; if (dut.rf_q[2] !== 32'hF800_0000) begin failures++; $display("FAIL srai got=%h exp=F8000000", dut.rf_q[2]); end
    checks++; if (dut.rf_q[6] !== 32'h0800_0000) begin failures++; $display("FAIL srli got=%h exp=08000000", dut.rf_q[6]); end
    checks++; if (dut.rf_q[3] !== 32'd1) begin failures++; $display("FAIL sltu got=%h exp=1", dut.rf_q[3]); end
    checks++; if (dut.rf_q[4] !== 32'd1) begin failures++; $display("FAIL slt got=%h exp=1", dut.rf_q[4]); end
    checks++; if (dut.rf_q[7] !== 32'hF000_0000) begin failures++; $display("FAIL sub got=%h exp=F0000000", dut.rf_q[7]); end
    checks++; if (dut.rf_q[9] !== 32'hFFFF_FF0F) begin failures++; $display("FAIL xori got=%h exp=FFFFFF0F", dut.rf_q[9]); end
  endtask

  task automatic test_memory();
    begin_prog(32'd0);
    dut.imem[0]  = u_t(20'h12345, 5'd1, 7'h37);
    dut.imem[1]  = i_t(12'h678, 5'd1, 3'd0, 5'd1, 7'h13);
    dut.imem[2]  = s_t(12'h010, 5'd1, 5'd0, 3'd2);
    dut.imem[3]  = i_t(12'h013, 5'd0, 3'd0, 5'd2, 7'h03);
    dut.imem[4]  = i_t(12'h0AB, 5'd0, 3'd0, 5'd3, 7'h13);
    dut.imem[5]  = s_t(12'h011, 5'd3, 5'd0, 3'd0);
    dut.imem[6]  = i_t(12'h012, 5'd0, 3'd1, 5'd4, 7'h03);
    dut.imem[7]  = i_t(12'h011, 5'd0, 3'd4, 5'd5, 7'h03);
    dut.imem[8]  = i_t(12'h011, 5'd0, 3'd0, 5'd6, 7'h03);
    dut.imem[9]  = s_t(12'h016, 5'd3, 5'd0, 3'd1);
    dut.imem[10] = i_t(12'h016, 5'd0, 3'd1, 5'd7, 7'h03);
    release_rst();
    run(12);
    checks++; if (dut.rf_q[2] !== 32'h0000_0012) begin failures++; $display("FAIL lb_0x13 got=%h exp=00000012", dut.rf_q[2]); end
    checks++; if (dut.dmem[4] !== 32'h1234_AB78) begin failures++; $display("FAIL sb_dmem4 got=%h exp=1234AB78", dut.dmem[4]); end
    checks++; if (dut.rf_q[4] !== 32'h0000_1234) begin failures++; $display("FAIL lh_0x12 got=%h exp=00001234", dut.rf_q[4]); end
    checks++; if (dut.rf_q[5] !== 32'h0000_00AB) begin failures++; $display("FAIL lbu_0x11 got=%h exp=000000AB", dut.rf_q[5]); end
    checks++; if (dut.rf_q[6] !== 32'hFFFF_FFAB) begin failures++; $display("FAIL lb_sign got=%h exp=FFFFFFAB", dut.rf_q[6]); end
    checks++; if (dut.dmem[5] !== 32'h00AB_0000) begin failures++; $display("FAIL sh_upper got=%h exp=00AB0000", dut.dmem[5]); end
    checks++; if (dut.rf_q[7] !== 32'h0000_00AB) begin failures++; $display("FAIL lh_upper got=%h exp=000000AB", dut.rf_q[7]); end
  endtask

  task automatic test_control();
    begin_prog(32'd0);
    dut.imem[0]  = i_t(12'd0, 5'd0, 3'd0, 5'd5, 7'h13);
    dut.imem[1]  = i_t(12'd10, 5'd0, 3'd0, 5'd6, 7'h13);
    dut.imem[2]  = i_t(12'd1, 5'd5, 3'd0, 5'd5, 7'h13);
    dut.imem[3]  = b_t(13'h1FFC, 5'd6, 5'd5, 3'd1);
    dut.imem[4]  = i_t(12'h041, 5'd0, 3'd0, 5'd7, 7'h13);
    dut.imem[5]  = i_t(12'd0, 5'd7, 3'd0, 5'd8, 7'h67);
    dut.imem[16] = i_t(12'd7, 5'd0, 3'd0, 5'd9, 7'h13);
    release_rst();
    run(25);
    checks++; if (dut.rf_q[5] !== 32'd10) begin failures++; $display("FAIL bne_loop got=%h exp=0000000a", dut.rf_q[5]); end
    checks++; if (dut.rf_q[8] !== 32'h18) begin failures++; $display("FAIL jalr_link got=%h exp=00000018", dut.rf_q[8]); end
    checks++; if (dut.rf_q[9] !== 32'd7) begin failures++; $display("FAIL jalr_target got=%h exp=7", dut.rf_q[9]); end
    checks++; if (dut.pc_q !== 32'h44) begin failures++; $display("FAIL ctl_pc got=%h exp=00000044", dut.pc_q); end
  endtask

  task automatic test_jal_branch();
    begin_prog(32'd0);
    dut.imem[2]  = j_t(21'h20, 5'd1);
    dut.imem[10] = i_t(12'hFFF, 5'd0, 3'd0, 5'd2, 7'h13);
    dut.imem[11] = b_t(13'd8, 5'd2, 5'd0, 3'd6);
    dut.imem[12] = i_t(12'd1, 5'd0, 3'd0, 5'd20, 7'h13);
    dut.imem[13] = b_t(13'd8, 5'd2, 5'd0, 3'd4);
    dut.imem[14] = u_t(20'h00001, 5'd3, 7'h17);
    release_rst();
    run(3);
    checks++; if (dut.rf_q[1] !== 32'hC) begin failures++; $display("FAIL jal_link got=%h exp=0000000c", dut.rf_q[1]); end
    checks++; if (dut.pc_q !== 32'h28) begin failures++; $display("FAIL jal_pc got=%h exp=00000028", dut.pc_q); end
    run(4);
    checks++; if (dut.pc_q !== 32'h3C) begin failures++; $display("FAIL branch_pc got=%h exp=0000003c", dut.pc_q); end
    checks++; if (dut.rf_q[20] !== 32'd0) begin failures++; $display("FAIL bltu_skip got=%h exp=0", dut.rf_q[20]); end
    checks++; if (dut.rf_q[3] !== 32'h1038) begin failures++; $display("FAIL auipc got=%h exp=00001038", dut.rf_q[3]); end
  endtask

  task automatic test_csr();
    begin_prog(32'd0);
    dut.imem[0] = i_t(12'h340, 5'd5, 3'd5, 5'd1, 7'h73);
    dut.imem[1] = i_t(12'h340, 5'd0, 3'd2, 5'd2, 7'h73);
    dut.imem[2] = i_t(12'h00A, 5'd0, 3'd0, 5'd3, 7'h13);
    dut.imem[3] = i_t(12'h340, 5'd3, 3'd2, 5'd4, 7'h73);
    dut.imem[4] = i_t(12'h340, 5'd3, 3'd7, 5'd5, 7'h73);
    dut.imem[5] = i_t(12'h123, 5'd3, 3'd1, 5'd6, 7'h73);
    dut.imem[6] = i_t(12'h340, 5'd0, 3'd2, 5'd7, 7'h73);
    dut.imem[7] = i_t(12'h340, 5'd0, 3'd1, 5'd8, 7'h73);
    release_rst();
    run(8);
    checks++; if (dut.rf_q[1] !== 32'd0) begin failures++; $display("FAIL csrrwi_old got=%h exp=0", dut.rf_q[1]); end
    checks++; if (dut.rf_q[2] !== 32'd5) begin failures++; $display("FAIL csrrs_x0 got=%h exp=5", dut.rf_q[2]); end
    checks++; if (dut.rf_q[4] !== 32'd5) begin failures++; $display("FAIL csrrs_old got=%h exp=5", dut.rf_q[4]); end
    checks++; if (dut.rf_q[5] !== 32'hF) begin failures++; $display("FAIL csrrci_old got=%h exp=f", dut.rf_q[5]); end
    checks++; if (dut.rf_q[6] !== 32'd0) begin failures++; $display("FAIL csr_unimpl got=%h exp=0", dut.rf_q[6]); end
    checks++; if (dut.rf_q[7] !== 32'hC) begin failures++; $display("FAIL csrrci_new got=%h exp=c", dut.rf_q[7]); end
    checks++; if (dut.rf_q[8] !== 32'hC || dut.mscratch_q !== 32'd0) begin
      failures++; $display("FAIL csrrw_x0 got x8=%h msc=%h exp x8=c msc=0", dut.rf_q[8], dut.mscratch_q);
    end
  endtask

  task automatic test_completion();
    bit done = 1'b0;
    begin_prog(32'd0);
    dut.imem[0]  = i_t(12'd3, 5'd0, 3'd0, 5'd1, 7'h13);
    dut.imem[1]  = i_t(12'd4, 5'd0, 3'd0, 5'd2, 7'h13);
    dut.imem[2]  = r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    dut.imem[3]  = i_t(12'd7, 5'd0, 3'd0, 5'd4, 7'h13);
    dut.imem[4]  = b_t(13'd16, 5'd4, 5'd3, 3'd1);
    dut.imem[5]  = u_t(20'hFFFF1, 5'd10, 7'h37);
    dut.imem[6]  = i_t(12'h234, 5'd10, 3'd0, 5'd10, 7'h13);
    dut.imem[7]  = j_t(21'd12, 5'd0);
    dut.imem[8]  = u_t(20'h12350, 5'd10, 7'h37);
    dut.imem[9]  = i_t(12'hFFF, 5'd10, 3'd0, 5'd10, 7'h13);
    dut.imem[10] = i_t(12'h340, 5'd10, 3'd1, 5'd0, 7'h73);
    dut.imem[11] = j_t(21'd0, 5'd0);
    release_rst();
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (dut.mscratch_q == 32'hFFFF_1234 || dut.mscratch_q == 32'h1234_FFFF) done = 1'b1;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL completion_timeout msc=%h exp=FFFF1234", dut.mscratch_q); end
    else if (dut.mscratch_q !== 32'hFFFF_1234) begin failures++; $display("FAIL completion got=%h exp=FFFF1234", dut.mscratch_q); end
  endtask

  task automatic test_reset_midrun();
    begin_prog(32'h0000_1000);
    dut.imem[0] = i_t(12'h055, 5'd0, 3'd0, 5'd1, 7'h13);
    dut.imem[1] = s_t(12'h020, 5'd1, 5'd0, 3'd2);
    dut.imem[2] = i_t(12'd1, 5'd2, 3'd0, 5'd2, 7'h13);
    dut.imem[3] = j_t(21'h1FFFFC, 5'd0);
    release_rst();
    run(10);
    checks++; if (dut.rf_q[2] !== 32'd4) begin failures++; $display("FAIL loop_count got=%h exp=4", dut.rf_q[2]); end
    #2;
    boot_addr = 32'h0000_2000;
    rst = 1'b1;
    #1;
    checks++; if (dut.pc_q !== 32'h2000) begin failures++; $display("FAIL midrst_pc got=%h exp=00002000", dut.pc_q); end
    checks++; if (dut.rf_q[1] !== 32'd0 || dut.rf_q[2] !== 32'd0) begin
      failures++; $display("FAIL midrst_regs got x1=%h x2=%h exp 0", dut.rf_q[1], dut.rf_q[2]);
    end
    checks++; if (dut.dmem[8] !== 32'h55) begin failures++; $display("FAIL midrst_dmem got=%h exp=00000055", dut.dmem[8]); end
    run(1);
    release_rst();
    run(2);
    checks++; if (dut.rf_q[1] !== 32'h55 || dut.pc_q !== 32'h2008) begin
      failures++; $display("FAIL restart got x1=%h pc=%h exp x1=55 pc=2008", dut.rf_q[1], dut.pc_q);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_control();
    test_jal_branch();
    test_csr();
    test_completion();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
